parallel_fir_pipeline: RTL and testbench

L-parallel, pipelined, runtime-programmable FIR filter. Generalises the fixed three-parallel pipelined filter to a parameterised lane count and tap count, and adds valid-qualified streaming and a shadowed coefficient bank. Each cycle it accepts LANES consecutive samples and produces LANES filtered outputs at a fixed latency.

---
 rtl/parallel_fir_pipeline.sv | 149 ++++++++++++++
 tb/tb_parallel_fir_pipeline.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_fir_pipeline.sv
// parallel_fir_pipeline
//   L-parallel, pipelined, runtime-programmable FIR filter. Each accepted block
//   carries LANES consecutive samples (lane 0 oldest). It produces LANES outputs
//   y[n] = sum_i h[i]*x[n-i] a fixed LAT = 2+$clog2(TAPS) edges later.
//   Pipeline: window register -> registered products -> registered adder tree
//   (one level per clock) -> output register.
//   Coefficients are written into a shadow bank and copied to the active bank
//   by a commit.
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active-low
//   in_valid     din block valid on this edge
//   din          LANES x DW signed samples, lane j at [j*DW +: DW]
//   out_valid    dout block valid (one cycle per accepted block)
//   dout         LANES x OW signed results, lane j at [j*OW +: OW]; held while !out_valid
//   coef_we      write coef_data into shadow[coef_addr] (ignored if addr >= TAPS)
//   coef_addr    shadow bank index
//   coef_data    signed coefficient
//   coef_commit  copy the whole shadow bank into the active bank
module parallel_fir_pipeline #(
    parameter int LANES = 3,
    parameter int TAPS  = 8,
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int OW    = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [LANES*DW-1:0]      din,
    output logic                     out_valid,
    output logic [LANES*OW-1:0]      dout,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [CW-1:0]            coef_data,
    input  logic                     coef_commit
);

    localparam int LVL = $clog2(TAPS);      // adder tree depth
    localparam int NP  = 1 << LVL;          // tree leaves, zero padded past TAPS
    localparam int LAT = 2 + LVL;
    localparam int SW  = DW + CW + LVL;     // tree node width, cannot overflow
    localparam int WN  = TAPS - 1 + LANES;  // history plus current block

    generate
        if (OW < SW) begin : g_ow_check
            $error("parallel_fir_pipeline: OW must be >= DW+CW+$clog2(TAPS)");
        end
        if (LANES < 1 || TAPS < 2) begin : g_size_check
            $error("parallel_fir_pipeline: need LANES >= 1 and TAPS >= 2");
        end
    endgenerate

    logic signed [DW-1:0] hist_q     [TAPS-1];
    logic signed [DW-1:0] seq        [WN];
    logic signed [DW-1:0] win_q      [WN];
    logic signed [CW-1:0] coef_shd_q [TAPS];
    logic signed [CW-1:0] coef_act_q [TAPS];
    logic signed [SW-1:0] tree_q     [LVL+1][LANES][NP];
    logic signed [OW-1:0] dout_q     [LANES];
    logic [LAT:0]         vld_q;

    // seq[m]: oldest history sample at m=0, newest input sample at m=WN-1.
    // Output lane j, tap i uses seq[TAPS-1+j-i].
    always_comb begin
        seq = '{default: '0};
        for (int unsigned m = 0; m < WN; m++) begin
            if (m < TAPS - 1) begin
                seq[m] = hist_q[m];
            end else begin
                seq[m] = din[(m - (TAPS - 1)) * DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q  <= '0;
            hist_q <= '{default: '0};
            win_q  <= '{default: '0};
            tree_q <= '{default: '0};
            dout_q <= '{default: '0};
            for (int unsigned i = 0; i < TAPS; i++) begin
                coef_shd_q[i] <= (i == 0) ? CW'(1) : '0;
                coef_act_q[i] <= (i == 0) ? CW'(1) : '0;
            end
        end else begin
            vld_q <= {vld_q[LAT-1:0], in_valid};

            // The history only advances on accepted blocks; bubbles leave it intact.
            if (in_valid) begin
                win_q <= seq;
                for (int unsigned m = 0; m < TAPS - 1; m++) begin
                    hist_q[m] <= seq[m + LANES];
                end
            end

            // The commit sees the pre-write shadow when both fire on the same edge.
            if (coef_commit) begin
                coef_act_q <= coef_shd_q;
            end
            if (coef_we && (32'(coef_addr) < TAPS)) begin
                coef_shd_q[coef_addr] <= coef_data;
            end

            // A block accepted at edge k forms its products at edge k+1 from the
            // active bank as it stands after edge k. A commit on edge k therefore
            // applies to that block, and earlier blocks keep the old bank.
            for (int unsigned j = 0; j < LANES; j++) begin
                for (int unsigned i = 0; i < NP; i++) begin
                    if (i < TAPS) begin
                        tree_q[0][j][i] <= SW'(coef_act_q[i]) * SW'(win_q[TAPS - 1 + j - i]);
                    end else begin
                        tree_q[0][j][i] <= '0;
                    end
                end
            end

            for (int unsigned lv = 1; lv <= LVL; lv++) begin
                for (int unsigned j = 0; j < LANES; j++) begin
                    for (int unsigned n = 0; n < NP; n++) begin
                        if (n < (NP >> lv)) begin
                            tree_q[lv][j][n] <= tree_q[lv-1][j][2*n] + tree_q[lv-1][j][2*n+1];
                        end else begin
                            tree_q[lv][j][n] <= '0;
                        end
                    end
                end
            end

            if (vld_q[LAT-1]) begin
                for (int unsigned j = 0; j < LANES; j++) begin
                    dout_q[j] <= OW'(tree_q[LVL][j][0]);
                end
            end
        end
    end

    assign out_valid = vld_q[LAT];

    genvar gj;
    generate
        for (gj = 0; gj < LANES; gj++) begin : g_dout
            assign dout[gj*OW +: OW] = dout_q[gj];
        end
    endgenerate

endmodule

// File: tb/tb_parallel_fir_pipeline.sv
module tb_parallel_fir_pipeline;

    localparam int LANES = 3;
    localparam int TAPS  = 8;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int OW    = 64;
    localparam int LAT   = 5;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic [LANES*DW-1:0]     din;
    logic                    out_valid;
    logic [LANES*OW-1:0]     dout;
    logic                    coef_we;
    logic [$clog2(TAPS)-1:0] coef_addr;
    logic [CW-1:0]           coef_data;
    logic                    coef_commit;

    always #5 clk = ~clk;

    parallel_fir_pipeline #(
        .LANES(LANES), .TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .din(din),
        .out_valid(out_valid), .dout(dout),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_commit(coef_commit)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: coefficient banks, recent accepted samples and the
    // queue of blocks still owed by the filter, each with its due cycle.
    typedef struct packed {
        logic [31:0]                   due;
        logic [LANES-1:0][63:0]        y;
    } blk_t;

    longint                  act [TAPS];
    longint                  shd [TAPS];
    longint                  xs  [$];
    blk_t                    pend[$];
    logic [LANES-1:0][63:0]  exp_dout;
    int                      cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d required %0d", tag, $signed(obs), $signed(exp_v));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) begin
            act[i] = (i == 0) ? 1 : 0;
            shd[i] = (i == 0) ? 1 : 0;
        end
        xs.delete();
        pend.delete();
        exp_dout = '0;
    endtask

    task automatic model_edge();
        blk_t   b;
        int     base;
        longint acc;
        cyc++;
        if (!rst) begin
            model_reset();
        end else begin
            if (coef_commit) begin
                for (int i = 0; i < TAPS; i++) act[i] = shd[i];
            end
            if (coef_we && int'(coef_addr) < TAPS) begin
                shd[coef_addr] = longint'($signed(coef_data));
            end
            if (in_valid) begin
                for (int j = 0; j < LANES; j++) begin
                    xs.push_back(longint'($signed(din[j*DW +: DW])));
                end
                base  = xs.size() - LANES;
                b.due = 32'(cyc + LAT);
                for (int j = 0; j < LANES; j++) begin
                    acc = 0;
                    for (int i = 0; i < TAPS; i++) begin
                        if (base + j - i >= 0) acc += act[i] * xs[base + j - i];
                    end
                    b.y[j] = acc;
                end
                pend.push_back(b);
                while (xs.size() > TAPS - 1) void'(xs.pop_front());
            end
        end
    endtask

    task automatic check_out();
        logic ev;
        ev = (pend.size() > 0) && (int'(pend[0].due) == cyc);
        chk("out_valid", 64'(out_valid), 64'(ev));
        if (ev) begin
            exp_dout = pend[0].y;
            void'(pend.pop_front());
        end
        for (int j = 0; j < LANES; j++) begin
            chk($sformatf("dout[%0d]@%0d", j, cyc), dout[j*OW +: OW], exp_dout[j]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_out();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic set_din(input longint a, input longint b, input longint c);
        din[0*DW +: DW] = DW'(a);
        din[1*DW +: DW] = DW'(b);
        din[2*DW +: DW] = DW'(c);
    endtask

    task automatic send(input longint a, input longint b, input longint c);
        set_din(a, b, c);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wr(input int addr, input longint data);
        coef_we   = 1'b1;
        coef_addr = ($clog2(TAPS))'(addr);
        coef_data = CW'(data);
        tick();
        coef_we   = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    // Fixed expectations on the held output lanes, independent of the model.
    task automatic hold3(input string tag, input longint a, input longint b, input longint c);
        chk({tag, "_l0"}, dout[0*OW +: OW], 64'(a));
        chk({tag, "_l1"}, dout[1*OW +: OW], 64'(b));
        chk({tag, "_l2"}, dout[2*OW +: OW], 64'(c));
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; din = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
        model_reset();

        // Reset state
        idle(2);
        rst = 1'b1;
        hold3("reset_dout", 0, 0, 0);

        // Identity coefficients, single block, latency 5
        send(1, 2, 3);
        idle(7);
        hold3("identity", 1, 2, 3);

        // All-ones taps, continuous 100s: ramp then steady 800
        do_reset();
        for (int i = 0; i < TAPS; i++) wr(i, 1);
        commit();
        for (int k = 0; k < 6; k++) send(100, 100, 100);
        idle(6);
        hold3("ones_steady", 800, 800, 800);

        // Extremes, no overflow
        do_reset();
        for (int i = 0; i < TAPS; i++) wr(i, -32768);
        commit();
        for (int k = 0; k < 6; k++) send(-32768, -32768, -32768);
        idle(6);
        hold3("neg_neg", 64'sd8589934592, 64'sd8589934592, 64'sd8589934592);
        for (int i = 0; i < TAPS; i++) wr(i, 32767);
        commit();
        for (int k = 0; k < 6; k++) send(-32768, -32768, -32768);
        idle(6);
        hold3("neg_pos", -64'sd8589672448, -64'sd8589672448, -64'sd8589672448);

        // Bubbles do not shift the history; out_valid follows in_valid
        do_reset();
        wr(1, 2);
        commit();
        send(1, 2, 3);
        idle(2);
        send(4, 5, 6);
        idle(6);
        hold3("bubbles", 10, 13, 16);

        // Commit on the same edge as a block applies to that block only
        do_reset();
        wr(0, 2);
        send(5, 5, 5);
        coef_commit = 1'b1;
        send(5, 5, 5);
        coef_commit = 1'b0;
        idle(6);
        hold3("commit_edge", 10, 10, 10);

        // Write and commit on the same edge: commit takes the pre-write shadow
        coef_we = 1'b1; coef_addr = 3'd1; coef_data = 16'd7; coef_commit = 1'b1;
        tick();
        coef_we = 1'b0; coef_commit = 1'b0;
        send(1, 0, 0);
        idle(6);
        hold3("we_commit_same", 2, 0, 0);
        commit();
        send(1, 0, 0);
        idle(6);
        hold3("we_commit_later", 2, 7, 0);

        // Reset with blocks in flight discards them and restores identity
        send(9, 9, 9);
        send(8, 8, 8);
        send(7, 7, 7);
        do_reset();
        idle(6);
        send(1, 2, 3);
        idle(6);
        hold3("post_reset", 1, 2, 3);

        // Randomized traffic, coefficient updates and occasional resets
        for (int k = 0; k < 400; k++) begin
            rst         = ($urandom_range(0, 99) != 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            din         = {$urandom(), $urandom()};
            coef_we     = ($urandom_range(0, 3) == 0);
            coef_addr   = ($clog2(TAPS))'($urandom_range(0, TAPS - 1));
            coef_data   = CW'($urandom());
            coef_commit = ($urandom_range(0, 7) == 0);
            tick();
        end
        rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; coef_commit = 1'b0;
        idle(LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
